// File: rtl/mmio_arb_pkg.sv
// ============================================================================
//  Module  : mmio_arb_pkg
//  Brief   : Shared types and default sizes for the MMIO bus arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 16;
    localparam int DEF_TIMEOUT = 255;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_arbiter_rr_pick.sv
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin picker; first set request after ptr.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic          w_found;
    logic [IW-1:0] w_j;

    // Search order ptr+1, ptr+2, ..., ptr (mod N): the last winner gets lowest priority.
    always_comb begin
        any     = |req;
        idx     = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int i = 1; i <= N; i++) begin
            w_j = IW'((int'(ptr) + i) % N);
            if (!w_found && req[w_j]) begin
                w_found = 1'b1;
                idx     = w_j;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_arbiter.sv
// ============================================================================
//  Module  : mmio_arbiter
//  Brief   : Round-robin arbiter for the shared peripheral bus, one outstanding
//            transaction, registered bus drive and bus-stall timeout.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ*DW-1:0]   wdata_i,
    output logic [NREQ-1:0]      done_o,
    output logic                 err_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 busy_o,
    output logic                 bus_valid_o,
    output logic                 bus_we_o,
    output logic [AW-1:0]        bus_addr_o,
    output logic [DW-1:0]        bus_wdata_o,
    input  logic                 bus_ready_i,
    input  logic [DW-1:0]        bus_rdata_i
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_CW = max_int(8, $clog2(TIMEOUT + 1));
    localparam logic [c_IW-1:0] c_PTR_RST = c_IW'(NREQ - 1);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t         r_state;
    logic [c_IW-1:0]    r_ptr;
    logic [c_IW-1:0]    r_win;
    logic [c_CW-1:0]    r_cnt;
    logic               r_err;
    logic [NREQ-1:0]    r_done;
    logic [DW-1:0]      r_rdata;
    logic               r_busy;
    logic               r_valid;
    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;

    logic               w_any;
    logic [c_IW-1:0]    w_idx;
    logic               w_timeout;
    logic [NREQ-1:0]    w_win_onehot;
    logic [AW-1:0]      w_addr  [NREQ];
    logic [DW-1:0]      w_wdata [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign w_addr[k]  = addr_i[k*AW +: AW];
        assign w_wdata[k] = wdata_i[k*DW +: DW];
    end

    rr_pick #(
        .N   (NREQ)
    ) u_rr_pick (
        .req (req_i),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // A ready on the final wait cycle is checked first, so the transfer wins over expiry.
    assign w_timeout    = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);
    assign w_win_onehot = NREQ'(1) << r_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= c_PTR_RST;
            r_win   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_done  <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win   <= w_idx;
                        r_we    <= we_i[w_idx];
                        r_addr  <= w_addr[w_idx];
                        r_wdata <= w_wdata[w_idx];
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus_ready_i) begin
                        if (!r_we) begin
                            r_rdata <= bus_rdata_i;
                        end
                        r_err   <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= w_win_onehot;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_valid <= 1'b0;
                        r_done  <= w_win_onehot;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                RESP: begin
                    r_done  <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_win;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign done_o      = r_done;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign busy_o      = r_busy;
    assign bus_valid_o = r_valid;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mmio_arbiter.sv
// ============================================================================
//  Module  : tb_mmio_arbiter
//  Brief   : Self-checking bench for mmio_arbiter (NREQ=2, TIMEOUT=4).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr, wdata;
    logic [1:0]  done;
    logic        err;
    logic [15:0] rdata;
    logic        busy, bvalid, bwe;
    logic [15:0] baddr, bwdata;
    logic        bready;
    logic [15:0] brdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mmio_arbiter #(
        .NREQ        (2),
        .AW          (16),
        .DW          (16),
        .TIMEOUT     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .done_o      (done),
        .err_o       (err),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .bus_valid_o (bvalid),
        .bus_we_o    (bwe),
        .bus_addr_o  (baddr),
        .bus_wdata_o (bwdata),
        .bus_ready_i (bready),
        .bus_rdata_i (brdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req, we;
        logic [15:0] a0, a1, d0, d1;
        logic        rdy;
        logic [15:0] brd;
        logic [1:0]  e_done;
        logic        e_err;
        logic [15:0] e_rdata;
        logic        e_busy, e_valid, e_we;
        logic [15:0] e_addr, e_wdata;
    } vec_t;

    vec_t tv [20];

    function automatic vec_t mk(
        input logic r, input logic [1:0] rq, input logic [1:0] w,
        input logic [15:0] a0, input logic [15:0] a1,
        input logic [15:0] d0, input logic [15:0] d1,
        input logic rdy, input logic [15:0] brd,
        input logic [1:0] ed, input logic ee, input logic [15:0] er,
        input logic eb, input logic ev, input logic ew,
        input logic [15:0] ea, input logic [15:0] ewd);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.rdy = rdy; v.brd = brd; v.e_done = ed; v.e_err = ee; v.e_rdata = er;
        v.e_busy = eb; v.e_valid = ev; v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] w,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        req = rq; we = w; addr = {a1, a0}; wdata = {d1, d0};
    endtask

    // Random-phase requester and transaction bookkeeping
    logic [1:0]  pend, just_done;
    logic [15:0] ra [2];
    logic [15:0] rd [2];
    logic        rw [2];
    int          waitc [2];
    logic        pv, pwe, rdy_seen, lat_we;
    logic [15:0] pa, pwd, cap, exp_rdata, lat_addr, lat_wd;
    int          nval;

    initial begin
        int n;
        logic got;
        int k;

        // Stimulus: cycle table (single read, dual writes, alternation, stalled read)
        tv[0]  = mk(0, 2'b01, 2'b00, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 1, 16'hBEEF,
                    2'b00, 0, 16'h0000, 1, 1, 0, 16'h1000, 16'h0000);
        tv[1]  = mk(0, 2'b01, 2'b00, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 1, 16'hBEEF,
                    2'b01, 0, 16'hBEEF, 1, 0, 0, 16'h1000, 16'h0000);
        tv[2]  = mk(0, 2'b00, 2'b00, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000,
                    2'b00, 0, 16'hBEEF, 0, 0, 0, 16'h1000, 16'h0000);
        tv[3]  = mk(1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000,
                    2'b00, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        tv[4]  = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b00, 0, 16'h0000, 1, 1, 1, 16'hC000, 16'h1111);
        tv[5]  = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b01, 0, 16'h0000, 1, 0, 1, 16'hC000, 16'h1111);
        tv[6]  = mk(0, 2'b10, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b00, 0, 16'h0000, 0, 0, 1, 16'hC000, 16'h1111);
        tv[7]  = mk(0, 2'b10, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b00, 0, 16'h0000, 1, 1, 1, 16'hC002, 16'h2222);
        tv[8]  = mk(0, 2'b10, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b10, 0, 16'h0000, 1, 0, 1, 16'hC002, 16'h2222);
        tv[9]  = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b00, 0, 16'h0000, 0, 0, 1, 16'hC002, 16'h2222);
        tv[10] = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b00, 0, 16'h0000, 1, 1, 1, 16'hC000, 16'h1111);
        tv[11] = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b01, 0, 16'h0000, 1, 0, 1, 16'hC000, 16'h1111);
        tv[12] = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b00, 0, 16'h0000, 0, 0, 1, 16'hC000, 16'h1111);
        tv[13] = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b00, 0, 16'h0000, 1, 1, 1, 16'hC002, 16'h2222);
        tv[14] = mk(0, 2'b11, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 1, 16'h0000,
                    2'b10, 0, 16'h0000, 1, 0, 1, 16'hC002, 16'h2222);
        tv[15] = mk(0, 2'b00, 2'b11, 16'hC000, 16'hC002, 16'h1111, 16'h2222, 0, 16'h0000,
                    2'b00, 0, 16'h0000, 0, 0, 1, 16'hC002, 16'h2222);
        tv[16] = mk(0, 2'b10, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 16'h0000,
                    2'b00, 0, 16'h0000, 1, 1, 0, 16'h0004, 16'h0000);
        tv[17] = mk(0, 2'b10, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 16'h5A5A,
                    2'b00, 0, 16'h0000, 1, 1, 0, 16'h0004, 16'h0000);
        tv[18] = mk(0, 2'b10, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 1, 16'h5A5A,
                    2'b10, 0, 16'h5A5A, 1, 0, 0, 16'h0004, 16'h0000);
        tv[19] = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 16'h0000,
                    2'b00, 0, 16'h5A5A, 0, 0, 0, 16'h0004, 16'h0000);

        rst = 1'b1; bready = 1'b0; brdata = '0;
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        step();
        step();
        chk("reset_done",  {30'd0, done}, 32'd0);
        chk("reset_err",   {31'd0, err}, 32'd0);
        chk("reset_rdata", {16'd0, rdata}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, bvalid}, 32'd0);
        chk("reset_addr",  {16'd0, baddr}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            rst = tv[i].rst; bready = tv[i].rdy; brdata = tv[i].brd;
            drive(tv[i].req, tv[i].we, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1);
            step();
            chk($sformatf("row%0d_done", i),  {30'd0, done},   {30'd0, tv[i].e_done});
            chk($sformatf("row%0d_err", i),   {31'd0, err},    {31'd0, tv[i].e_err});
            chk($sformatf("row%0d_rdata", i), {16'd0, rdata},  {16'd0, tv[i].e_rdata});
            chk($sformatf("row%0d_busy", i),  {31'd0, busy},   {31'd0, tv[i].e_busy});
            chk($sformatf("row%0d_valid", i), {31'd0, bvalid}, {31'd0, tv[i].e_valid});
            chk($sformatf("row%0d_bwe", i),   {31'd0, bwe},    {31'd0, tv[i].e_we});
            chk($sformatf("row%0d_baddr", i), {16'd0, baddr},  {16'd0, tv[i].e_addr});
            chk($sformatf("row%0d_bwd", i),   {16'd0, bwdata}, {16'd0, tv[i].e_wdata});
        end
        rst = 1'b0;

        // Timed-out read: valid for exactly TIMEOUT cycles, err set, rdata kept
        bready = 1'b0; brdata = 16'hDEAD;
        drive(2'b01, 2'b00, 16'h2000, 16'h0000, 16'h0000, 16'h0000);
        n = 0; got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            step();
            if (bvalid) n++;
            if (done != 2'b00) got = 1'b1;
        end
        chk("to_done_seen",   {31'd0, got}, 32'd1);
        chk("to_valid_cycles", n, 4);
        chk("to_done",        {30'd0, done}, 32'd1);
        chk("to_err",         {31'd0, err}, 32'd1);
        chk("to_rdata_kept",  {16'd0, rdata}, 32'h5A5A);
        drive(2'b00, 2'b00, 16'h2000, 16'h0000, 16'h0000, 16'h0000);
        step();
        chk("to_after_err",  {31'd0, err}, 32'd0);
        chk("to_after_busy", {31'd0, busy}, 32'd0);

        // Ready on the final timeout cycle: transfer wins
        drive(2'b01, 2'b00, 16'h2002, 16'h0000, 16'h0000, 16'h0000);
        n = 0;
        step();
        if (bvalid) n++;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bvalid) n++;
        end
        bready = 1'b1; brdata = 16'h1234;
        step();
        chk("last_valid_cycles", n, 4);
        chk("last_done",  {30'd0, done}, 32'd1);
        chk("last_err",   {31'd0, err}, 32'd0);
        chk("last_rdata", {16'd0, rdata}, 32'h1234);
        bready = 1'b0;
        drive(2'b00, 2'b00, 16'h2002, 16'h0000, 16'h0000, 16'h0000);
        step();

        // Reset while in ISSUE: abort, no done, pointer back to favour requester 0
        drive(2'b10, 2'b10, 16'h0000, 16'h3000, 16'h0000, 16'h7777);
        step();
        chk("rstmid_issue_valid", {31'd0, bvalid}, 32'd1);
        chk("rstmid_issue_addr",  {16'd0, baddr}, 32'h3000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_valid", {31'd0, bvalid}, 32'd0);
        chk("rstmid_busy",  {31'd0, busy}, 32'd0);
        chk("rstmid_done",  {30'd0, done}, 32'd0);
        drive(2'b11, 2'b11, 16'h3100, 16'h3000, 16'h8888, 16'h7777);
        step();
        chk("rstmid_regrant_addr",  {16'd0, baddr}, 32'h3100);
        chk("rstmid_regrant_wdata", {16'd0, bwdata}, 32'h8888);
        bready = 1'b1;
        step();
        chk("rstmid_regrant_done", {30'd0, done}, 32'd1);
        bready = 1'b0;
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        step();

        // Random requests and stalls against a transaction scoreboard
        pend = '0; just_done = '0; exp_rdata = 16'h0000;
        waitc[0] = 0; waitc[1] = 0;
        nval = 0; rdy_seen = 1'b0; cap = '0; lat_we = 1'b0; lat_addr = '0; lat_wd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int j = 0; j < 2; j++) begin
                if (!pend[j] && !just_done[j] && ($urandom_range(0, 1) == 1)) begin
                    pend[j]  = 1'b1;
                    ra[j]    = 16'($urandom);
                    rd[j]    = 16'($urandom);
                    rw[j]    = 1'($urandom_range(0, 1));
                    waitc[j] = 0;
                end
            end
            just_done = '0;
            drive(pend, {rw[1], rw[0]}, ra[0], ra[1], rd[0], rd[1]);
            bready = ($urandom_range(0, 2) == 0);
            brdata = 16'($urandom);
            pv = bvalid; pwe = bwe; pa = baddr; pwd = bwdata;
            step();
            if (pv) begin
                nval++;
                if (bready) begin
                    rdy_seen = 1'b1;
                    if (!pwe) cap = brdata;
                end
                if (!bready && bvalid) begin
                    chk("rnd_stable_addr", {16'd0, baddr}, {16'd0, pa});
                    chk("rnd_stable_we",   {31'd0, bwe}, {31'd0, pwe});
                    chk("rnd_stable_wd",   {16'd0, bwdata}, {16'd0, pwd});
                end
            end else if (bvalid) begin
                nval = 0; rdy_seen = 1'b0;
                lat_addr = baddr; lat_we = bwe; lat_wd = bwdata;
            end
            chk("rnd_done_onehot0", {31'd0, $onehot0(done)}, 32'd1);
            if (done != 2'b00) begin
                k = done[1] ? 1 : 0;
                chk("rnd_done_pending", {31'd0, pend[k]}, 32'd1);
                chk("rnd_addr",  {16'd0, lat_addr}, {16'd0, ra[k]});
                chk("rnd_we",    {31'd0, lat_we}, {31'd0, rw[k]});
                chk("rnd_wdata", {16'd0, lat_wd}, {16'd0, rd[k]});
                chk("rnd_err",   {31'd0, err}, {31'd0, !rdy_seen});
                if (!rdy_seen) chk("rnd_to_cycles", nval, 4);
                if (rdy_seen && !lat_we) exp_rdata = cap;
                chk("rnd_rdata", {16'd0, rdata}, {16'd0, exp_rdata});
                if (pend[1-k]) begin
                    waitc[1-k]++;
                    chk("rnd_starve", {31'd0, waitc[1-k] <= 1}, 32'd1);
                end
                waitc[k]     = 0;
                pend[k]      = 1'b0;
                just_done[k] = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
